// File: rtl/digit_scan_pkg.sv
// ============================================================================
// Module : digit_scan_pkg
// Desc   : Shared defaults, select constant and width helper for digit_scan_mux
// Rev    : 1.0
// ============================================================================
`default_nettype none

package digit_scan_pkg;

  localparam int c_num_digits_def   = 4;
  localparam int c_digit_w_def      = 4;
  localparam int c_scan_div_def     = 100000;
  localparam int c_dead_cycles_def  = 2;
  localparam int c_blink_frames_def = 50;

  // Wide enough for the largest supported digit count; callers slice it down.
  localparam logic [7:0] c_sel_all_off = 8'hFF;

  function automatic int pos_width(input int num_digits);
    return (num_digits > 1) ? $clog2(num_digits) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/scan_prescaler.sv
// ============================================================================
// Module : scan_prescaler
// Desc   : Slot-period counter 0..SCAN_DIV-1 with enable and synchronous clear
// Rev    : 1.0
// ============================================================================
`default_nettype none

module scan_prescaler #(
  parameter int SCAN_DIV = 100000
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_enable,
  input  logic                        i_clear,
  output logic                        o_tick,
  output logic [$clog2(SCAN_DIV)-1:0] o_count_next
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] c_terminal = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;

  // Tick is independent of i_clear so the caller may derive its clear from it.
  assign o_tick = i_enable && (r_count == c_terminal);

  always_comb begin
    w_count_next = r_count;
    if (i_clear) begin
      w_count_next = '0;
    end else if (i_enable) begin
      w_count_next = (r_count == c_terminal) ? '0 : r_count + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign o_count_next = w_count_next;

endmodule

`default_nettype wire

// File: rtl/digit_scan_mux.sv
// ============================================================================
// Module : digit_scan_mux
// Desc   : Time-multiplexed 7-segment digit scanner with frame snapshot,
//          dead time and blanking. Optional blink via DIGIT_SCAN_BLINK_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module digit_scan_mux
  import digit_scan_pkg::*;
#(
  parameter int NUM_DIGITS  = c_num_digits_def,
  parameter int DIGIT_W     = c_digit_w_def,
  parameter int SCAN_DIV    = c_scan_div_def,
  parameter int DEAD_CYCLES = c_dead_cycles_def
`ifdef DIGIT_SCAN_BLINK_EN
  ,
  parameter int BLINK_FRAMES = c_blink_frames_def
`endif
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_enable,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] i_digits,
  input  logic [NUM_DIGITS-1:0]         i_blank_mask,
`ifdef DIGIT_SCAN_BLINK_EN
  input  logic [NUM_DIGITS-1:0]         i_blink_mask,
`endif
  output logic [DIGIT_W-1:0]            o_value,
  output logic [NUM_DIGITS-1:0]         o_digit_sel,
  output logic [$clog2(NUM_DIGITS)-1:0] o_digit_pos,
  output logic                          o_frame_start
);

  localparam int POS_W = pos_width(NUM_DIGITS);
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [POS_W-1:0]      c_last_pos = POS_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] c_all_off  = c_sel_all_off[NUM_DIGITS-1:0];

  logic                          r_running;
  logic [POS_W-1:0]              r_pos;
  logic [NUM_DIGITS*DIGIT_W-1:0] r_shadow;
  logic [DIGIT_W-1:0]            r_value;
  logic [NUM_DIGITS-1:0]         r_sel;
  logic                          r_frame_start;

  logic                  w_tick;
  logic [CNT_W-1:0]      w_cnt_next;
  logic                  w_start;
  logic [POS_W-1:0]      w_pos_next;
  logic [DIGIT_W-1:0]    w_value_next;
  logic [NUM_DIGITS-1:0] w_sel_lit;
  logic                  w_dead;
  logic                  w_blink_dark;

  scan_prescaler #(
    .SCAN_DIV (SCAN_DIV)
  ) u_prescaler (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_enable     (i_enable),
    .i_clear      (!i_enable || !r_running),
    .o_tick       (w_tick),
    .o_count_next (w_cnt_next)
  );

  // A frame starts on the wrap out of the last slot, or on the first enabled cycle.
  assign w_start    = i_enable && (!r_running || (w_tick && (r_pos == c_last_pos)));
  assign w_pos_next = w_start ? '0 : (w_tick ? r_pos + 1'b1 : r_pos);

  assign w_value_next = w_start ? i_digits[DIGIT_W-1:0]
                                : r_shadow[w_pos_next*DIGIT_W +: DIGIT_W];

  assign w_sel_lit = ~(NUM_DIGITS'(1) << w_pos_next);
  assign w_dead    = (w_cnt_next < CNT_W'(DEAD_CYCLES));

`ifdef DIGIT_SCAN_BLINK_EN
  localparam int FW = $clog2(BLINK_FRAMES + 1);

  logic          r_phase;
  logic [FW-1:0] r_frame_cnt;
  logic          w_wrap;
  logic          w_phase_toggle;

  // Only wraps count, so the first frame after an idle start is always lit.
  assign w_wrap         = w_start && r_running;
  assign w_phase_toggle = w_wrap && (r_frame_cnt == FW'(BLINK_FRAMES - 1));
  assign w_blink_dark   = (r_phase ^ w_phase_toggle) && i_blink_mask[w_pos_next];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_phase     <= 1'b0;
      r_frame_cnt <= '0;
    end else if (w_wrap) begin
      r_phase     <= r_phase ^ w_phase_toggle;
      r_frame_cnt <= w_phase_toggle ? '0 : r_frame_cnt + 1'b1;
    end
  end
`else
  assign w_blink_dark = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_running     <= 1'b0;
      r_pos         <= '0;
      r_shadow      <= '0;
      r_value       <= '0;
      r_sel         <= c_all_off;
      r_frame_start <= 1'b0;
    end else if (!i_enable) begin
      r_running     <= 1'b0;
      r_pos         <= '0;
      r_sel         <= c_all_off;
      r_frame_start <= 1'b0;
    end else begin
      r_running     <= 1'b1;
      r_pos         <= w_pos_next;
      r_value       <= w_value_next;
      r_frame_start <= w_start;
      if (w_start) begin
        r_shadow <= i_digits;
      end
      if (w_dead || i_blank_mask[w_pos_next] || w_blink_dark) begin
        r_sel <= c_all_off;
      end else begin
        r_sel <= w_sel_lit;
      end
    end
  end

  assign o_value       = r_value;
  assign o_digit_sel   = r_sel;
  assign o_digit_pos   = r_pos[$clog2(NUM_DIGITS)-1:0];
  assign o_frame_start = r_frame_start;

endmodule

`default_nettype wire

// File: doc/digit_scan_mux.md
# digit_scan_mux

Parametrised time-multiplexed display scanner for the clock's 7-segment path. It replaces the fixed 4-input digit mux plus external position counter with a single block. The block has its own scan prescaler, a position counter with non-power-of-two wrap, and a frame-coherent digit snapshot. It also provides anti-ghosting dead time and per-digit blanking. It sits between the time/BCD registers and the segment decoder and anode drivers.

## Interface
- NUM_DIGITS, 4, number of digit slots (2..8)
- DIGIT_W, 4, bits per digit value
- SCAN_DIV, 100000, clock cycles each digit is held (>= 2)
- DEAD_CYCLES, 2, all-anodes-off cycles at the start of each slot (0 .. SCAN_DIV-1)
- i_clk  input  1  system clock
- i_reset_n  input  1  asynchronous, active-low reset
- i_enable  input  1  scan enable; low = display dark
- i_digits  input  NUM_DIGITS*DIGIT_W  packed digits; slot k at bits [k*DIGIT_W +: DIGIT_W]; slot 0 = rightmost
- i_blank_mask  input  NUM_DIGITS  1 = slot never lit
- o_value  output  DIGIT_W  value for current slot, to segment decoder
- o_digit_sel  output  NUM_DIGITS  active-low one-hot anode select
- o_digit_pos  output  $clog2(NUM_DIGITS)  current slot index
- o_frame_start  output  1  one-cycle pulse when a new frame begins

## Operation
- Prescaler: counts 0..SCAN_DIV-1 on enabled cycles. The terminal count is the slot tick.
- Slot tick: pos advances pos+1. It wraps from NUM_DIGITS-1 to 0, and must not rely on power-of-two overflow.
- Snapshot: shadow register loads i_digits at every frame start. o_value always comes from the shadow, never live input, so a mid-frame change never tears a frame.
- Frame start happens on:
  - the wrap to pos 0;
  - the first enabled cycle after reset;
  - the first enabled cycle after i_enable rises.
  
  On a frame start, o_value takes slot 0 directly from i_digits.
- Dead time: for DEAD_CYCLES cycles after each slot change, o_digit_sel = all ones. After that, o_digit_sel = ~(1 << pos), unless i_blank_mask[pos] = 1, in which case it stays all ones.
- Blanking does not change timing or o_value; it only suppresses the anode.
- i_enable low: next edge sets o_digit_sel all ones, pos 0, prescaler 0, o_frame_start 0. The shadow is held.
- i_blank_mask is sampled live each cycle.

## Timing
- Reset values: o_value 0, o_digit_sel all ones, o_digit_pos 0, o_frame_start 0, prescaler 0, shadow 0.
- All outputs are registered. No combinational path from any input to any output.
- o_digit_pos, o_value and the start of dead time all change on the same edge as the slot tick.
- o_frame_start is high exactly in the cycle where o_digit_pos first shows 0 of a new frame.
- Slot period = SCAN_DIV cycles. Lit time per slot = SCAN_DIV - DEAD_CYCLES. Frame period = NUM_DIGITS*SCAN_DIV.
- Reset asserted mid-frame: outputs return to reset values immediately (asynchronous). The first enabled cycle after release is a frame start.
- i_enable toggling in the same cycle as a slot tick: disable takes priority.

## Configuration
- DIGIT_SCAN_BLINK_EN defined:
  - adds parameter BLINK_FRAMES (default 50) and input i_blink_mask [NUM_DIGITS];
  - an internal frame counter toggles a blink phase every BLINK_FRAMES frames; phase resets to 0 (lit);
  - while phase = 1, slots with i_blink_mask set are forced dark, like blanking.
- Not defined: no port, no counter, no phase logic. Behaviour is exactly as above.

## Structure
- Package digit_scan_pkg holds the default parameter values, the all-off select constant, and the position-width function.
- Sub-module scan_prescaler: counter with enable and synchronous clear, emitting the one-cycle slot tick. Everything else stays in digit_scan_mux.

## Test plan
Default bench setting: NUM_DIGITS=4, DIGIT_W=4, SCAN_DIV=4, DEAD_CYCLES=1, unless a line says otherwise.

- Reset held, then released with i_enable=0 -> o_digit_sel=4'b1111, o_value=0, o_digit_pos=0, o_frame_start=0.
- i_digits=16'h1234, enable -> pos 0,1,2,3,0, each for 4 cycles. o_value 4,3,2,1. Per slot: one cycle of 1111, then 1110/1101/1011/0111. o_frame_start once per 16 cycles.
- i_digits changes to 16'h5678 while pos=1 -> rest of frame still shows 2,1. Next frame shows 8,7,6,5.
- i_blank_mask=4'b1000 -> slot 3 select stays 1111 for all 4 cycles. Slot timing and o_value=1 are unchanged.
- i_enable dropped at pos=2 -> next cycle 1111, pos 0. Re-enable -> o_frame_start on the first cycle, snapshot reloaded.
- NUM_DIGITS=6, DIGIT_SCAN_BLINK_EN with BLINK_FRAMES=2, i_blink_mask=6'b000001 -> pos wraps 5->0. Slot 0 is lit for 2 frames, dark for 2, and repeats.
